tick_gen: RTL and testbench
===========================

TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000: input clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4: number of independent tick channels (1..16).
REQ-003 SHALL have parameter CNT_W, default 26: counter/divisor width; SHALL hold CLK_FREQ-1.
REQ-004 SHALL have port clk  input  1: single clock, all logic on posedge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port en  input  N_CH: per-channel count enable.
REQ-007 SHALL have port sync_clr  input  1: synchronous phase-align clear of all channels.
REQ-008 SHALL have port cfg_we  input  1: divisor write strobe, one cycle.
REQ-009 SHALL have port cfg_ch  input  4: target channel index.
REQ-010 SHALL have port cfg_div  input  CNT_W: new divisor (period in clk cycles).
REQ-011 SHALL have port tick  output  N_CH: single-cycle pulse per period, registered.
REQ-012 SHALL have port wave  output  N_CH: 50%-duty square wave, toggles on each tick.
REQ-013 SHALL have port cfg_pend  output  N_CH: written divisor not yet active.
REQ-014 SHALL have port cfg_err  output  1: one-cycle pulse on rejected write.

Function
REQ-015 Per channel k: counter cnt, active divisor act_div, pending divisor pend_div plus valid flag.
REQ-016 en[k]=1: cnt increments each cycle; at cnt==act_div-1, cnt<=0 and tick[k]<=1 next cycle; otherwise tick[k]<=0.
REQ-017 Period SHALL be exactly act_div cycles; first tick after reset visible in the cycle after the act_div-th rising edge following reset release.
REQ-018 wave[k] SHALL toggle in the same cycle tick[k] is registered high.
REQ-019 act_div==1: tick[k] held high every cycle; wave toggles every cycle.
REQ-020 en[k]=0: cnt and wave[k] hold; tick[k]=0; re-enable resumes from held cnt.
REQ-021 cfg_we with cfg_ch<N_CH and cfg_div>=1: pend_div<=cfg_div, cfg_pend[ch]<=1.
REQ-022 Pending divisor SHALL take effect at the channel's next wrap (glitch-free period change), clearing cfg_pend; a disabled channel applies it on the next cycle.
REQ-023 Second write before apply SHALL overwrite pend_div; only the last value applies.
REQ-024 cfg_div==0 or cfg_ch>=N_CH: write dropped, no state change, cfg_err=1 next cycle.
REQ-025 sync_clr: all cnt<=0, tick<=0, wave<=0, any pending divisor applied immediately; overrides wrap in the same cycle.
REQ-026 sync_clr and valid cfg_we in the same cycle: written value becomes act_div directly, cfg_pend stays 0.
REQ-027 Wrap and cfg_we for the same channel in the same cycle: new value goes pending, applies at the following wrap.

Reset
REQ-028 rst_n low: cnt=0, tick=0, wave=0, cfg_pend=0, cfg_err=0, act_div[k]=CLK_FREQ/(k+1) (1 Hz, 2 Hz, 3 Hz, ... channels).
REQ-029 Reset mid-period or with a pending write SHALL discard counts and pending values.

Structure
REQ-030 Package tick_gen_pkg SHALL hold the default CLK_FREQ, default CNT_W and a default-divisor function CLK_FREQ/(k+1).
REQ-031 Per-channel logic SHALL be sub-module tick_chan, instantiated N_CH times by generate; tick_gen holds only config decode and cfg_err.

Verification (CLK_FREQ=20, N_CH=4, en=all 1)
REQ-032 Reset release -> ticks at periods 20/10/6/5 cycles; ch0 first tick in the cycle after edge 20.
REQ-033 Write ch1 div=4 mid-period -> cfg_pend[1]=1 until the next ch1 wrap, then period 4; the old period is never truncated.
REQ-034 Write ch2=8 then ch2=3 before wrap -> only 3 applies; cfg_div=0 or cfg_ch=5 -> cfg_err pulse, no change.
REQ-035 sync_clr at arbitrary cycle -> all ticks and waves realign; ch0 and ch1 ticks coincide 20 cycles later.
REQ-036 en[0] low for 7 cycles mid-period -> ch0 tick delayed exactly 7 cycles; ch3 div=1 -> tick constantly high.
REQ-037 rst_n asserted with a pending write -> all outputs 0 immediately, defaults restored.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared defaults for the tick generator: clock frequency, counter width and
// the reset-time divisor of each channel (channel k ticks at k+1 Hz).
package tick_gen_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_CNT_W    = 26;

    function automatic int unsigned defaultDiv(input int unsigned clkFreq,
                                               input int unsigned chIdx);
        return clkFreq / (chIdx + 1);
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: free-running divider with a double-buffered divisor so a
// period change only ever lands on a wrap boundary.
module tick_chan import tick_gen_pkg::*; #(
    parameter int unsigned      CNT_W   = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEF_DIV = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_clr_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             tick_o,
    output logic             wave_o,
    output logic             pend_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] actDiv_q, actDiv_d;
    logic [CNT_W-1:0] pendDiv_q, pendDiv_d;
    logic             pendVld_q, pendVld_d;
    logic             tick_q, tick_d;
    logic             wave_q, wave_d;
    logic             wrap;

    // >= rather than == so a count held while disabled past a newly shortened divisor still wraps.
    assign wrap = (cnt_q >= actDiv_q - 1'b1);

    always_comb begin
        cnt_d     = cnt_q;
        actDiv_d  = actDiv_q;
        pendDiv_d = pendDiv_q;
        pendVld_d = pendVld_q;
        tick_d    = 1'b0;
        wave_d    = wave_q;

        if (sync_clr_i) begin
            cnt_d     = '0;
            wave_d    = 1'b0;
            pendVld_d = 1'b0;
            if (wr_i) begin
                actDiv_d = div_i;
            end else if (pendVld_q) begin
                actDiv_d = pendDiv_q;
            end
        end else begin
            if (en_i) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    wave_d = ~wave_q;
                    if (pendVld_q) begin
                        actDiv_d  = pendDiv_q;
                        pendVld_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (pendVld_q) begin
                actDiv_d  = pendDiv_q;
                pendVld_d = 1'b0;
            end
            // A write landing on a wrap edge stays pending for the following wrap.
            if (wr_i) begin
                pendDiv_d = div_i;
                pendVld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            actDiv_q  <= DEF_DIV;
            pendDiv_q <= '0;
            pendVld_q <= 1'b0;
            tick_q    <= 1'b0;
            wave_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            actDiv_q  <= actDiv_d;
            pendDiv_q <= pendDiv_d;
            pendVld_q <= pendVld_d;
            tick_q    <= tick_d;
            wave_q    <= wave_d;
        end
    end

    assign tick_o = tick_q;
    assign wave_o = wave_q;
    assign pend_o = pendVld_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: decodes divisor writes onto the channels and
// flags rejected writes; all timing lives in tick_chan.
module tick_gen import tick_gen_pkg::*; #(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_clr,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  wave,
    output logic [N_CH-1:0]  cfg_pend,
    output logic             cfg_err
);

    logic divZero;
    logic chBad;
    logic wrValid;
    logic cfgErr_q, cfgErr_d;

    assign divZero  = (cfg_div == '0);
    assign chBad    = (32'(cfg_ch) >= N_CH);
    assign wrValid  = cfg_we && !divZero && !chBad;
    assign cfgErr_d = cfg_we && (divZero || chBad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgErr_q <= 1'b0;
        end else begin
            cfgErr_q <= cfgErr_d;
        end
    end

    assign cfg_err = cfgErr_q;

    for (genvar k = 0; k < N_CH; k++) begin : gChan
        localparam logic [CNT_W-1:0] ChDefDiv = CNT_W'(defaultDiv(CLK_FREQ, k));
        logic chWr;

        assign chWr = wrValid && (cfg_ch == 4'(k));

        tick_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (ChDefDiv)
        ) uChan (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .en_i       (en[k]),
            .sync_clr_i (sync_clr),
            .wr_i       (chWr),
            .div_i      (cfg_div),
            .tick_o     (tick[k]),
            .wave_o     (wave[k]),
            .pend_o     (cfg_pend[k])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed scoreboard bench for tick_gen: stimulus schedules time-stamped
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_tick_gen;

    localparam int CNT_W  = 8;
    localparam int F_TICK = 0;
    localparam int F_WAVE = 1;
    localparam int F_PEND = 2;
    localparam int F_ERR  = 3;

    typedef struct {
        int         cyc;
        string      name;
        int         field;
        logic [3:0] mask;
        logic [3:0] val;
    } expT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       en = 4'hF;
    logic             sync_clr = 1'b0;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_ch = 4'd0;
    logic [CNT_W-1:0] cfg_div = '0;
    logic [3:0]       tick, wave, cfg_pend;
    logic             cfg_err;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    expT expQ[$];
    expT monE;
    expT leftE;
    int  relCyc;

    tick_gen #(.CLK_FREQ(20), .N_CH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .tick(tick), .wave(wave), .cfg_pend(cfg_pend), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Insert keeping the queue ordered by cycle so the monitor only looks at the head.
    task automatic expectAt(input int dc, input string name, input int field,
                            input logic [3:0] mask, input logic [3:0] val);
        expT e;
        int  idx;
        e.cyc = cyc + dc; e.name = name; e.field = field; e.mask = mask; e.val = val;
        idx = expQ.size();
        for (int i = 0; i < expQ.size(); i++) begin
            if (expQ[i].cyc > e.cyc) begin
                idx = i;
                break;
            end
        end
        expQ.insert(idx, e);
    endtask

    task automatic applyStimulus(input logic [3:0] ch, input logic [CNT_W-1:0] div);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = div;
        waitCycles(1);
        cfg_we  = 1'b0;
    endtask

    task automatic checkOutput(input expT e);
        logic [3:0] actual;
        case (e.field)
            F_TICK:  actual = tick;
            F_WAVE:  actual = wave;
            F_PEND:  actual = cfg_pend;
            default: actual = {3'b000, cfg_err};
        endcase
        checks++;
        if (e.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else if ((actual & e.mask) !== (e.val & e.mask)) begin
            errors++;
            $display("[TB] FAIL %s @%0d: got %b required %b (mask %b)",
                     e.name, cyc, actual & e.mask, e.val & e.mask, e.mask);
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            monE = expQ.pop_front();
            checkOutput(monE);
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        waitCycles(2);
        expectAt(1, "rst_tick", F_TICK, 4'hF, 4'h0);
        expectAt(1, "rst_wave", F_WAVE, 4'hF, 4'h0);
        expectAt(1, "rst_pend", F_PEND, 4'hF, 4'h0);
        expectAt(1, "rst_err",  F_ERR,  4'h1, 4'h0);
        waitCycles(1);

        // Reset release: default periods 20/10/6/5.
        rst_n = 1'b1;
        expectAt(5,  "ch3_first",   F_TICK, 4'b1000, 4'b1000);
        expectAt(6,  "ch2_first",   F_TICK, 4'b0100, 4'b0100);
        expectAt(10, "ch1_first",   F_TICK, 4'b0010, 4'b0010);
        expectAt(19, "ch0_early",   F_TICK, 4'b0001, 4'b0000);
        expectAt(20, "ch01_tick20", F_TICK, 4'b0011, 4'b0011);
        expectAt(20, "ch01_wave20", F_WAVE, 4'b0011, 4'b0001);
        expectAt(21, "ch0_pulse1",  F_TICK, 4'b0001, 4'b0000);
        waitCycles(25);

        // ch1 divisor 4 written mid-period: old period finishes first.
        expectAt(1,  "ch1_pend_set",  F_PEND, 4'b0010, 4'b0010);
        expectAt(4,  "ch1_pend_hold", F_PEND, 4'b0010, 4'b0010);
        expectAt(4,  "ch1_no_trunc",  F_TICK, 4'b0010, 4'b0000);
        expectAt(5,  "ch1_old_wrap",  F_TICK, 4'b0010, 4'b0010);
        expectAt(5,  "ch1_pend_clr",  F_PEND, 4'b0010, 4'b0000);
        expectAt(8,  "ch1_new_gap",   F_TICK, 4'b0010, 4'b0000);
        expectAt(9,  "ch1_new_tick1", F_TICK, 4'b0010, 4'b0010);
        expectAt(13, "ch1_new_tick2", F_TICK, 4'b0010, 4'b0010);
        applyStimulus(4'd1, 8'd4);

        // ch2: 8 then 3 before the wrap, only 3 survives.
        expectAt(1,  "ch2_pend_set", F_PEND, 4'b0100, 4'b0100);
        expectAt(3,  "ch2_pend_hold", F_PEND, 4'b0100, 4'b0100);
        expectAt(4,  "ch2_pend_clr", F_PEND, 4'b0100, 4'b0000);
        expectAt(4,  "ch2_wrap",     F_TICK, 4'b0100, 4'b0100);
        expectAt(7,  "ch2_p3_a",     F_TICK, 4'b0100, 4'b0100);
        expectAt(9,  "ch2_gap",      F_TICK, 4'b0100, 4'b0000);
        expectAt(10, "ch2_p3_b",     F_TICK, 4'b0100, 4'b0100);
        applyStimulus(4'd2, 8'd8);
        applyStimulus(4'd2, 8'd3);

        // Rejected writes: zero divisor, then out-of-range channel.
        expectAt(1,  "err_div0",    F_ERR,  4'h1,    4'h1);
        expectAt(2,  "err_ch5",     F_ERR,  4'h1,    4'h1);
        expectAt(3,  "err_clear",   F_ERR,  4'h1,    4'h0);
        expectAt(2,  "err_no_pend", F_PEND, 4'b0001, 4'b0000);
        expectAt(11, "ch0_keep_a",  F_TICK, 4'b0001, 4'b0000);
        expectAt(12, "ch0_keep_b",  F_TICK, 4'b0001, 4'b0001);
        expectAt(12, "ch0_wave40",  F_WAVE, 4'b0001, 4'b0000);
        applyStimulus(4'd0, 8'd0);
        applyStimulus(4'd5, 8'd7);
        waitCycles(11);

        // sync_clr together with a valid write to ch3 (div 1).
        expectAt(1,  "clr_tick",     F_TICK, 4'hF,    4'h0);
        expectAt(1,  "clr_wave",     F_WAVE, 4'hF,    4'h0);
        expectAt(1,  "clr_pend3",    F_PEND, 4'b1000, 4'b0000);
        expectAt(2,  "ch3_div1_a",   F_TICK, 4'b1000, 4'b1000);
        expectAt(2,  "ch3_wave_a",   F_WAVE, 4'b1000, 4'b1000);
        expectAt(3,  "ch3_div1_b",   F_TICK, 4'b1000, 4'b1000);
        expectAt(3,  "ch3_wave_b",   F_WAVE, 4'b1000, 4'b0000);
        expectAt(4,  "ch2_realign",  F_TICK, 4'b0100, 4'b0100);
        expectAt(5,  "ch1_realign",  F_TICK, 4'b0010, 4'b0010);
        expectAt(5,  "ch1_wave_rl",  F_WAVE, 4'b0010, 4'b0010);
        expectAt(8,  "ch3_div1_c",   F_TICK, 4'b1000, 4'b1000);
        expectAt(20, "ch0_rl_early", F_TICK, 4'b0001, 4'b0000);
        expectAt(21, "ch01_coincide", F_TICK, 4'b0011, 4'b0011);
        sync_clr = 1'b1;
        applyStimulus(4'd3, 8'd1);
        sync_clr = 1'b0;
        waitCycles(25);

        // ch0 disabled for 7 cycles mid-period.
        expectAt(3,  "ch0_dis_tick", F_TICK, 4'b0001, 4'b0000);
        expectAt(5,  "ch0_dis_wave", F_WAVE, 4'b0001, 4'b0001);
        expectAt(15, "ch0_not_40",   F_TICK, 4'b0001, 4'b0000);
        expectAt(15, "ch1_unaffect", F_TICK, 4'b0010, 4'b0010);
        expectAt(21, "ch0_late_pre", F_TICK, 4'b0001, 4'b0000);
        expectAt(22, "ch0_late",     F_TICK, 4'b0001, 4'b0001);
        expectAt(22, "ch0_late_wv",  F_WAVE, 4'b0001, 4'b0000);
        en = 4'b1110;
        waitCycles(7);
        en = 4'b1111;
        waitCycles(20);

        // Reset with a pending write on ch0.
        expectAt(1, "ch0_pend_pre", F_PEND, 4'b0001, 4'b0001);
        applyStimulus(4'd0, 8'd3);
        waitCycles(1);
        rst_n = 1'b0;
        expectAt(0, "arst_tick", F_TICK, 4'hF, 4'h0);
        expectAt(0, "arst_wave", F_WAVE, 4'hF, 4'h0);
        expectAt(0, "arst_pend", F_PEND, 4'hF, 4'h0);
        expectAt(0, "arst_err",  F_ERR,  4'h1, 4'h0);
        waitCycles(2);
        rst_n = 1'b1;
        expectAt(1,  "rst2_pend",    F_PEND, 4'hF,    4'h0);
        expectAt(1,  "rst2_ch3_def", F_TICK, 4'b1000, 4'b0000);
        expectAt(3,  "rst2_ch0_def", F_TICK, 4'b0001, 4'b0000);
        expectAt(4,  "rst2_ch1_def", F_TICK, 4'b0010, 4'b0000);
        expectAt(5,  "rst2_ch3_tk",  F_TICK, 4'b1000, 4'b1000);
        expectAt(10, "rst2_ch1_tk",  F_TICK, 4'b0010, 4'b0010);
        expectAt(20, "rst2_ch0_tk",  F_TICK, 4'b0001, 4'b0001);
        waitCycles(25);

        for (int i = 0; i < 100 && expQ.size() > 0; i++) waitCycles(1);
        while (expQ.size() > 0) begin
            leftE = expQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: never sampled, required cycle %0d, now %0d", leftE.name, leftE.cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
